// File: rtl/pwm_cfg_ramp.sv
`default_nettype none
// ============================================================================
// Module   : pwm_cfg_ramp
// Brief    : Slews a linear duty setpoint toward its target and emits the
//            dithered 24-bit PWM config word, updated only on the PWM sync.
// Option   : PWM_CFG_RAMP_READBACK_EN adds the cur_o readback port.
// Revision : 1.0
// ============================================================================
module pwm_cfg_ramp #(
  parameter int         CCW  = 24,
  parameter logic [7:0] FULL = 8'd156,
  parameter int         VW   = 12
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           wr_i,
  input  logic [VW-1:0]  tgt_i,
  input  logic [VW-1:0]  step_i,
  input  logic           pwm_s_i,
  output logic [CCW-1:0] cfg_o,
  output logic           busy_o,
  output logic           done_o
`ifdef PWM_CFG_RAMP_READBACK_EN
  ,
  output logic [VW-1:0]  cur_o
`endif
);

  localparam logic [VW-1:0] c_TGT_MAX = VW'({FULL, 4'h0});

  logic [VW-1:0]  r_tgt;
  logic [VW-1:0]  r_step;
  logic [VW-1:0]  r_cur;
  logic [CCW-1:0] r_cfg;
  logic           r_busy;
  logic           r_done;

  logic [VW-1:0]  w_tgt_in;
  logic [VW-1:0]  w_nxt;
  logic [VW-1:0]  w_cur_new;
  logic [VW-1:0]  w_tgt_new;
  logic [VW:0]    w_diff;
  logic [VW:0]    w_stepped;
  logic           w_up;
  logic [15:0]    w_pat;

  always_comb begin
    w_tgt_in  = (tgt_i > c_TGT_MAX) ? c_TGT_MAX : tgt_i;
    w_up      = (r_tgt > r_cur);
    w_diff    = w_up ? ({1'b0, r_tgt} - {1'b0, r_cur}) : ({1'b0, r_cur} - {1'b0, r_tgt});
    w_stepped = w_up ? ({1'b0, r_cur} + {1'b0, r_step}) : ({1'b0, r_cur} - {1'b0, r_step});
    // A carry/borrow out of the step can only mean we passed the target: land on it.
    if (r_cur == r_tgt) begin
      w_nxt = r_cur;
    end else if ((r_step == '0) || (w_diff <= {1'b0, r_step}) || w_stepped[VW]) begin
      w_nxt = r_tgt;
    end else begin
      w_nxt = w_stepped[VW-1:0];
    end
    w_cur_new = pwm_s_i ? w_nxt : r_cur;
    w_tgt_new = wr_i ? w_tgt_in : r_tgt;
  end

  // Bit i is set when bitrev4(i) < fraction: f ones spread evenly over 16 periods.
  for (genvar gi = 0; gi < 16; gi++) begin : g_pat
    localparam logic [3:0] c_IDX = 4'(gi);
    localparam logic [3:0] c_REV = {c_IDX[0], c_IDX[1], c_IDX[2], c_IDX[3]};
    assign w_pat[gi] = (c_REV < w_nxt[3:0]);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_tgt  <= '0;
      r_step <= '0;
      r_cur  <= '0;
      r_cfg  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      if (wr_i) begin
        r_tgt  <= w_tgt_in;
        r_step <= step_i;
      end
      if (pwm_s_i) begin
        r_cur <= w_nxt;
        r_cfg <= {w_nxt[VW-1:VW-8], w_pat};
      end
      r_busy <= (w_cur_new != w_tgt_new);
      r_done <= pwm_s_i && (r_cur != r_tgt) && (w_nxt == r_tgt) && (w_tgt_new == w_nxt);
    end
  end

  assign cfg_o  = r_cfg;
  assign busy_o = r_busy;
  assign done_o = r_done;

`ifdef PWM_CFG_RAMP_READBACK_EN
  assign cur_o = r_cur;
`endif

endmodule
`default_nettype wire

// File: doc/pwm_cfg_ramp.md
Name: pwm_cfg_ramp

Overview:
- Upstream stage of the PWM DAC channel; one instance per PWM output.
- Converts a linear 12-bit duty setpoint (8-bit integer counts + 4-bit sixteenths) into the 24-bit PWM config word: integer in [23:16], 16-bit dither pattern in [15:0].
- Slews the applied value toward the setpoint in fixed steps.
- Updates the output word only on the PWM sync strobe, so the PWM always latches a consistent word at its 16-period boundary.

Parameters:
- CCW, 24: config word width; fixed layout, 8 integer bits + 16 pattern bits.
- FULL, 8'd156: 100% count; the integer part never exceeds FULL.
- VW, 12: linear value width; [11:4] integer, [3:0] sixteenths.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- wr_i  in  1  one-cycle write strobe for tgt_i/step_i
- tgt_i  in  VW  target duty value
- step_i  in  VW  slew step per sync; 0 = jump immediately
- pwm_s_i  in  1  sync strobe from the PWM; high one cycle before the PWM latches its config
- cfg_o  out  CCW  config word to the PWM
- busy_o  out  1  applied value != target
- done_o  out  1  one-cycle pulse when the applied value reaches the target

Behaviour:
- Reset (rstn low at an edge): tgt=0, step=0, cur=0, cfg_o=0, busy_o=0, done_o=0. Reset mid-ramp abandons the ramp immediately.
- Write: on wr_i, tgt <= clamp(tgt_i) and step <= step_i. The clamp caps tgt_i at FULL*16 (12'h9C0 for the default), so [3:0]=0 at full scale.
- Target changes never alter cfg_o directly; they only take effect at a sync.
- Sync (pwm_s_i high), next value nxt:
  - If cur == tgt: nxt = cur.
  - Else if step == 0 or |tgt-cur| <= step: nxt = tgt.
  - Else: nxt = cur ± step toward tgt.
  - No overshoot and no wrap. Arithmetic is VW+1 bits unsigned.
- At the sync edge:
  - cur <= nxt.
  - cfg_o <= {nxt[11:4], pat(nxt[3:0])}, so cfg_o is valid on the very next cycle when the PWM latches it.
  - cfg_o changes at no other edge.
- Dither pattern: pat(f) bit i = 1 iff bitrev4(i) < f, for i = 0..15. This gives exactly f ones, evenly spread. Examples: pat(0)=16'h0000, pat(5)=16'h1115, pat(8)=16'h5555.
- done_o: high for exactly the cycle after a sync edge at which cur != tgt and nxt == tgt.
- busy_o: registered, equal to (cur != tgt) as of the previous edge. It goes high the cycle after a write that creates a difference.
- Simultaneous wr_i and pwm_s_i:
  - The sync uses the old tgt/step.
  - The new tgt/step are captured and apply from the next sync.
  - busy_o/done_o reflect the state after both updates; done_o is suppressed if the new tgt differs from nxt.
- Back-to-back writes between syncs: the last write wins.
- pwm_s_i high on consecutive cycles: each cycle counts as a sync. This is legal but never produced by the PWM.

Optional Feature:
- PWM_CFG_RAMP_READBACK_EN defined: adds output port cur_o [VW-1:0], the registered applied value cur (reset 0), for bus readback. It updates at the same edges as cfg_o.
- Undefined: port and logic absent. All other behaviour is identical.

Test Plan:
- Reset: hold rstn=0 for 3 cycles during active syncs -> cfg_o=24'h000000, busy_o=0, done_o=0; no change on syncs while in reset.
- Jump: wr_i with tgt=12'h7A5, step=0, then a sync -> cfg_o=24'h7A1115 on the cycle after the sync; done_o pulses once; busy_o falls.
- Clamp: tgt=12'hA00, step=0, sync -> cfg_o=24'h9C0000; tgt reads as 12'h9C0 when the readback option is enabled.
- Ramp: from 0, tgt=12'h040, step=12'h010, 4 syncs -> cfg_o = 24'h010000, 24'h020000, 24'h030000, 24'h040000; done_o only after the 4th sync; busy_o high throughout the ramp.
- No overshoot: cur=12'h040, tgt=12'h035, step=12'h010, 1 sync -> cfg_o=24'h031115, done_o=1.
- Collision: wr_i of tgt=12'h100 in the same cycle as a sync during a ramp toward 12'h040 -> that sync steps toward 12'h040; later syncs head to 12'h100. Separately, rstn=0 mid-ramp -> cfg_o=0 on the next cycle.
